// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the M-stage memory access unit.
// Size codes, exception codes, FSM states and opcode field positions.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_ALIGN   = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT = 2'b10;
    localparam logic [1:0] EXC_SIZE    = 2'b11;

    localparam int OP_STORE = 3;
    localparam int OP_UNS   = 2;
    localparam int OP_SZ_HI = 1;
    localparam int OP_SZ_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    function automatic int size_bytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_ext.sv
// Load lane select plus sign/zero extension (combinational).
// Shifts the addressed lane to bit 0, then extends from the access width.
module mem_lane_ext
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int OFS_W = $clog2(DATA_W / 8),
    localparam int IDX_W = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [OFS_W-1:0]  ofs_i,
    input  logic [1:0]        size_i,
    input  logic              uns_i,
    output logic [DATA_W-1:0] ext_o
);

    logic [DATA_W-1:0] sh;
    logic [IDX_W-1:0]  msb;
    logic              fill;
    int                nbits;

    always_comb begin
        sh    = rdata_i >> {ofs_i, 3'b000};
        nbits = 8 * size_bytes(size_i);
        if (nbits > DATA_W) nbits = DATA_W;
        msb   = IDX_W'(nbits - 1);
        fill  = ~uns_i & sh[msb];
        ext_o = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ext_o[i] = (i < nbits) ? sh[i] : fill;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit owning the data-memory handshake.
// MEM_ALIGN_EXC_EN: raise a misalignment exception instead of force-aligning.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15,
    localparam int BE_W    = DATA_W / 8,
    localparam int OFS_W   = $clog2(BE_W),
    localparam int CNT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [1:0]        resp_exc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_e            state_q;
    logic [3:0]        op_q;
    logic [OFS_W-1:0]  ofs_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              resp_valid_q;
    logic [1:0]        resp_exc_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [BE_W-1:0]   mem_be_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [1:0]        sz_a;
    logic [OFS_W-1:0]  lmask;
    logic [OFS_W-1:0]  ofs_d;
    logic [BE_W-1:0]   be_d;
    logic [DATA_W-1:0] wdata_d;
    logic [15:0]       bmask;
    logic              illegal_d;
    logic              misalign_d;
    logic [DATA_W-1:0] ext_w;

    always_comb begin
        sz_a      = req_op[OP_SZ_HI:OP_SZ_LO];
        lmask     = OFS_W'((32'd1 << sz_a) - 32'd1);
`ifdef MEM_ALIGN_EXC_EN
        misalign_d = |(req_addr[OFS_W-1:0] & lmask);
`else
        misalign_d = 1'b0;
`endif
        // Aligned requests are unaffected; misaligned ones snap down.
        ofs_d     = req_addr[OFS_W-1:0] & ~lmask;
        illegal_d = (sz_a == SZ_D) && (DATA_W == 32);
        bmask     = (16'd1 << size_bytes(sz_a)) - 16'd1;
        be_d      = bmask[BE_W-1:0] << ofs_d;
        wdata_d   = '0;
        for (int i = 0; i < BE_W; i++) begin
            wdata_d[8*i +: 8] = req_wdata[8*(i % size_bytes(sz_a)) +: 8];
        end
    end

    mem_lane_ext #(
        .DATA_W(DATA_W)
    ) u_ext (
        .rdata_i(mem_rdata),
        .ofs_i  (ofs_q),
        .size_i (op_q[OP_SZ_HI:OP_SZ_LO]),
        .uns_i  (op_q[OP_UNS]),
        .ext_o  (ext_w)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            ofs_q        <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_exc_q   <= EXC_NONE;
            resp_rdata_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_exc_q   <= EXC_NONE;
                    state_q      <= ST_IDLE;
                    if (req_valid) begin
                        op_q  <= req_op;
                        ofs_q <= ofs_d;
                        cnt_q <= '0;
                        if (illegal_d) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_exc_q   <= EXC_SIZE;
                            resp_rdata_q <= '0;
                        end else if (misalign_d) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_exc_q   <= EXC_ALIGN;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q     <= ST_ACCESS;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_op[OP_STORE];
                            mem_addr_q  <= {req_addr[ADDR_W-1:OFS_W],
                                            {OFS_W{1'b0}}};
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_ready || cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_be_q     <= '0;
                        if (mem_ready) begin
                            resp_exc_q   <= EXC_NONE;
                            resp_rdata_q <= op_q[OP_STORE] ? '0 : ext_w;
                        end else begin
                            resp_exc_q   <= EXC_TIMEOUT;
                            resp_rdata_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state_q == ST_ACCESS);
    assign resp_valid = resp_valid_q;
    assign resp_exc   = resp_exc_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (32-bit and 64-bit instances).
// Expected values are hand-computed from the access semantics.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_exc;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        d_req_valid;
    logic [3:0]  d_req_op;
    logic [31:0] d_req_addr;
    logic [63:0] d_req_wdata;
    logic        d_busy;
    logic        d_resp_valid;
    logic [63:0] d_resp_rdata;
    logic [1:0]  d_resp_exc;
    logic        d_mem_req;
    logic        d_mem_we;
    logic [31:0] d_mem_addr;
    logic [7:0]  d_mem_be;
    logic [63:0] d_mem_wdata;
    logic [63:0] d_mem_rdata;
    logic        d_mem_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_exc(resp_exc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .MAX_WAIT(15)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(d_req_valid), .req_op(d_req_op),
        .req_addr(d_req_addr), .req_wdata(d_req_wdata),
        .busy(d_busy), .resp_valid(d_resp_valid),
        .resp_rdata(d_resp_rdata), .resp_exc(d_resp_exc),
        .mem_req(d_mem_req), .mem_we(d_mem_we), .mem_addr(d_mem_addr),
        .mem_be(d_mem_be), .mem_wdata(d_mem_wdata),
        .mem_rdata(d_mem_rdata), .mem_ready(d_mem_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid   = 1'b0; req_op = '0; req_addr = '0;
        req_wdata   = '0;   mem_rdata = '0; mem_ready = 1'b0;
        d_req_valid = 1'b0; d_req_op = '0; d_req_addr = '0;
        d_req_wdata = '0;   d_mem_rdata = '0; d_mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++;
        if ({busy, resp_valid, mem_req, mem_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl: got %b exp 0000",
                     {busy, resp_valid, mem_req, mem_we});
        end
        checks++;
        if (mem_be !== 4'h0 || resp_exc !== 2'b00 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: be=%h exc=%b rdata=%h exp 0/00/0",
                     mem_be, resp_exc, resp_rdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_byte(input logic uns, input logic [31:0] exp);
        req_valid = 1'b1;
        req_op    = {1'b0, uns, 2'b00};
        req_addr  = 32'h0000_1003;
        tick();
        req_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL lb_req: req=%b busy=%b we=%b exp 1/1/0",
                     mem_req, busy, mem_we);
        end
        checks++;
        if (mem_addr !== 32'h0000_1000 || mem_be !== 4'b1000) begin
            errors++;
            $display("FAIL lb_lane: addr=%h be=%b exp 00001000/1000",
                     mem_addr, mem_be);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h80FF_0011;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== exp || resp_exc !== 2'b00) begin
            errors++;
            $display("FAIL lb_resp uns=%0d: v=%b rdata=%h exc=%b exp 1/%h/00",
                     uns, resp_valid, resp_rdata, resp_exc, exp);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== exp || resp_exc !== 2'b00) begin
            errors++;
            $display("FAIL lb_hold: v=%b rdata=%h exc=%b exp 0/%h/00",
                     resp_valid, resp_rdata, resp_exc, exp);
        end
    endtask

    task automatic test_store_half();
        req_valid = 1'b1;
        req_op    = 4'b1001;
        req_addr  = 32'h0000_2002;
        req_wdata = 32'h0000_BEEF;
        tick();
        req_valid = 1'b0;
        checks++;
        if (mem_be !== 4'b1100 || mem_wdata !== 32'hBEEF_BEEF ||
            mem_we !== 1'b1 || mem_addr !== 32'h0000_2000) begin
            errors++;
            $display("FAIL sh_lane: be=%b wd=%h we=%b addr=%h exp 1100/beefbeef/1/00002000",
                     mem_be, mem_wdata, mem_we, mem_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL sh_resp: v=%b rdata=%h exp 1/00000000",
                     resp_valid, resp_rdata);
        end
        tick();
    endtask

    task automatic test_wait_states();
        int nbusy;
        int unstable;
        nbusy    = 0;
        unstable = 0;
        req_valid = 1'b1;
        req_op    = 4'b0010;
        req_addr  = 32'h0000_3000;
        tick();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        for (int c = 0; c < 4; c++) begin
            if (busy) nbusy++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3000 ||
                mem_be !== 4'hF || mem_we !== 1'b0) unstable++;
            if (c == 3) begin
                mem_ready = 1'b1;
                mem_rdata = 32'h1234_5678;
            end
            tick();
        end
        mem_ready = 1'b0;
        checks++;
        if (nbusy !== 4 || unstable !== 0) begin
            errors++;
            $display("FAIL lw_wait: busy_cycles=%0d unstable=%0d exp 4/0",
                     nbusy, unstable);
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h1234_5678 ||
            busy !== 1'b0) begin
            errors++;
            $display("FAIL lw_wait_resp: v=%b rdata=%h busy=%b exp 1/12345678/0",
                     resp_valid, resp_rdata, busy);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        req_valid = 1'b1;
        req_op    = 4'b0010;
        req_addr  = 32'h0000_3400;
        tick();
        req_valid = 1'b0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL timeout_len: busy_cycles=%0d exp 15", n);
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_exc !== 2'b10 ||
            mem_req !== 1'b0 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_resp: v=%b exc=%b req=%b rdata=%h exp 1/10/0/0",
                     resp_valid, resp_exc, mem_req, resp_rdata);
        end
        tick();
    endtask

    task automatic test_ready_at_limit();
        req_valid = 1'b1;
        req_op    = 4'b0010;
        req_addr  = 32'h0000_3800;
        tick();
        req_valid = 1'b0;
        repeat (14) tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_exc !== 2'b00 ||
            resp_rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL ready_wins: v=%b exc=%b rdata=%h exp 1/00/0badf00d",
                     resp_valid, resp_exc, resp_rdata);
        end
        tick();
    endtask

    task automatic test_align();
        req_valid = 1'b1;
        req_op    = 4'b0010;
        req_addr  = 32'h0000_4002;
        tick();
        req_valid = 1'b0;
`ifdef MEM_ALIGN_EXC_EN
        checks++;
        if (resp_valid !== 1'b1 || resp_exc !== 2'b01 ||
            mem_req !== 1'b0 || busy !== 1'b0 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL align_exc: v=%b exc=%b req=%b busy=%b rdata=%h exp 1/01/0/0/0",
                     resp_valid, resp_exc, mem_req, busy, resp_rdata);
        end
        tick();
`else
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_4000 || mem_be !== 4'hF) begin
            errors++;
            $display("FAIL align_force: req=%b addr=%h be=%b exp 1/00004000/1111",
                     mem_req, mem_addr, mem_be);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_exc !== 2'b00 ||
            resp_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL align_force_resp: v=%b exc=%b rdata=%h exp 1/00/cafef00d",
                     resp_valid, resp_exc, resp_rdata);
        end
        tick();
`endif
    endtask

    task automatic test_illegal_size();
        req_valid = 1'b1;
        req_op    = 4'b0011;
        req_addr  = 32'h0000_4100;
        tick();
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_exc !== 2'b11 ||
            mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_size: v=%b exc=%b req=%b busy=%b exp 1/11/0/0",
                     resp_valid, resp_exc, mem_req, busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1;
        req_op    = 4'b0101;
        req_addr  = 32'h0000_5002;
        tick();
        req_valid = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hA5A5_0000;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_A5A5) begin
            errors++;
            $display("FAIL b2b_first: v=%b rdata=%h exp 1/0000a5a5",
                     resp_valid, resp_rdata);
        end
        req_valid = 1'b1;
        req_op    = 4'b0001;
        req_addr  = 32'h0000_5000;
        tick();
        req_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_5000 ||
            mem_be !== 4'b0011 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_nobubble: req=%b addr=%h be=%b v=%b exp 1/00005000/0011/0",
                     mem_req, mem_addr, mem_be, resp_valid);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_8001;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL b2b_second: v=%b rdata=%h exp 1/ffff8001",
                     resp_valid, resp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        req_valid = 1'b1;
        req_op    = 4'b0010;
        req_addr  = 32'h0000_6000;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0 ||
            mem_be !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid: req=%b busy=%b v=%b be=%b exp 0/0/0/0000",
                     mem_req, busy, resp_valid, mem_be);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_after: v=%b busy=%b rdata=%h exp 0/0/0",
                     resp_valid, busy, resp_rdata);
        end
    endtask

    task automatic test_dword64();
        d_req_valid = 1'b1;
        d_req_op    = 4'b0011;
        d_req_addr  = 32'h0000_0008;
        tick();
        d_req_valid = 1'b0;
        checks++;
        if (d_mem_be !== 8'hFF || d_mem_addr !== 32'h0000_0008 ||
            d_mem_req !== 1'b1) begin
            errors++;
            $display("FAIL ld64_lane: be=%h addr=%h req=%b exp ff/00000008/1",
                     d_mem_be, d_mem_addr, d_mem_req);
        end
        d_mem_ready = 1'b1;
        d_mem_rdata = 64'hFEDC_BA98_7654_3210;
        tick();
        d_mem_ready = 1'b0;
        checks++;
        if (d_resp_valid !== 1'b1 || d_resp_rdata !== 64'hFEDC_BA98_7654_3210) begin
            errors++;
            $display("FAIL ld64_resp: v=%b rdata=%h exp 1/fedcba9876543210",
                     d_resp_valid, d_resp_rdata);
        end
        d_req_valid = 1'b1;
        d_req_op    = 4'b0010;
        d_req_addr  = 32'h0000_000C;
        tick();
        d_req_valid = 1'b0;
        checks++;
        if (d_mem_be !== 8'hF0 || d_mem_addr !== 32'h0000_0008) begin
            errors++;
            $display("FAIL lw64_lane: be=%h addr=%h exp f0/00000008",
                     d_mem_be, d_mem_addr);
        end
        d_mem_ready = 1'b1;
        d_mem_rdata = 64'h8000_0000_0000_0001;
        tick();
        d_mem_ready = 1'b0;
        checks++;
        if (d_resp_valid !== 1'b1 || d_resp_rdata !== 64'hFFFF_FFFF_8000_0000) begin
            errors++;
            $display("FAIL lw64_upper: v=%b rdata=%h exp 1/ffffffff80000000",
                     d_resp_valid, d_resp_rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_byte(1'b0, 32'hFFFF_FF80);
        test_load_byte(1'b1, 32'h0000_0080);
        test_store_half();
        test_wait_states();
        test_timeout();
        test_ready_at_limit();
        test_align();
        test_illegal_size();
        test_back_to_back();
        test_reset_mid_access();
        test_dword64();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Pipelined load/store front end for the M stage. Replaces the combinational load extender with a sequential unit that owns the data-memory handshake.
- Generates store byte enables and lane-replicated write data.
- Sign- or zero-extends load data for byte, half, word and (64-bit only) double accesses.
- Detects misalignment and stalls the pipeline while memory is busy, with a bus-timeout watchdog.

Parameters:
- DATA_W, 32, memory data width; 32 or 64 only.
- ADDR_W, 32, byte-address width.
- MAX_WAIT, 15, wait cycles allowed in ACCESS before a bus timeout; must be ≥1.
- Derived: BE_W = DATA_W/8; OFS_W = log2(BE_W).

Ports:
- clk, in, 1: clock; all logic is rising-edge.
- reset, in, 1: reset, synchronous and active-high.
- req_valid, in, 1: pipeline access request.
- req_op, in, 4: request opcode {store, unsigned, size[1:0]}; size 00=B, 01=H, 10=W, 11=D (D only when DATA_W=64).
- req_addr, in, ADDR_W: byte address.
- req_wdata, in, DATA_W: store data, right-aligned.
- busy, out, 1: stall to the pipeline.
- resp_valid, out, 1: one-cycle completion pulse.
- resp_rdata, out, DATA_W: extended load result; 0 for stores.
- resp_exc, out, 2: 00 none, 01 misaligned, 10 bus timeout, 11 illegal size.
- mem_req, out, 1: memory request.
- mem_we, out, 1: memory write enable.
- mem_addr, out, ADDR_W: lane-aligned address; low OFS_W bits are 0.
- mem_be, out, BE_W: byte enables.
- mem_wdata, out, DATA_W: lane-replicated store data.
- mem_rdata, in, DATA_W: raw memory read data.
- mem_ready, in, 1: access completes this cycle; mem_rdata is valid when it is high.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- busy = (state == ACCESS).
- A request is accepted when req_valid is high in IDLE or RESP. req_valid is ignored in ACCESS.
- On acceptance, op, addr offset and wdata are registered.
- Acceptance of a legal, aligned request → ACCESS next cycle.
- In ACCESS: mem_req=1. mem_we, mem_addr, mem_be and mem_wdata come from registers and are held stable until mem_ready.
- mem_ready=1 in ACCESS → RESP. In the RESP cycle resp_valid=1 and resp_rdata is computed from the mem_rdata captured at mem_ready.
- Latency: with a zero-wait memory, acceptance at cycle 0, mem_req at cycle 1, resp_valid at cycle 2.
- Wait counter:
  - Cleared on entry to ACCESS; increments each ACCESS cycle in which mem_ready=0.
  - When the counter reaches MAX_WAIT with mem_ready still 0: go to RESP with resp_exc=10 and resp_rdata=0, and drop mem_req.
  - If mem_ready=1 in the same cycle the counter reaches MAX_WAIT, mem_ready wins: normal completion.
- Illegal size (size=11 with DATA_W=32) → RESP next cycle with exc=11. No mem_req is issued.
- Store lanes:
  - mem_be = size mask shifted by the address offset.
  - mem_wdata = req_wdata[size bytes] replicated across all lanes.
- Load extension:
  - Select the lane at the offset.
  - Sign-extend from the top bit of the selected lane when unsigned=0; zero-extend when unsigned=1.
  - W on DATA_W=64 selects the upper word when addr[2]=1.
- When resp_valid=0: resp_rdata holds its last value and resp_exc=00.
- Reset (takes effect from any state, including mid-ACCESS):
  - State goes to IDLE.
  - busy, resp_valid, mem_req, mem_we=0; mem_be=0; resp_exc=00; resp_rdata=0; counter=0.
  - No completion pulse is generated for an aborted access.
- Back-to-back requests: a request accepted in the RESP cycle enters ACCESS next cycle, so there is no idle bubble.

Optional Feature:
- Macro: MEM_ALIGN_EXC_EN.
- Defined:
  - A misaligned request (H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0) → RESP next cycle with exc=01 and rdata=0.
  - No memory access is issued.
- Undefined:
  - Misalignment is never flagged.
  - The offset is force-aligned by clearing low bits to the access size, then the access proceeds normally.

Decomposition:
- Shared package mem_pkg holds:
  - Size encodings SZ_B/SZ_H/SZ_W/SZ_D.
  - Exception codes EXC_NONE/EXC_ALIGN/EXC_TIMEOUT/EXC_SIZE.
  - FSM state typedef.
  - Opcode field positions.
- One sub-module: mem_lane_ext, a combinational load lane select plus sign/zero extension, parametrised by DATA_W. The FSM, counter and store-lane logic stay in the top level.

Test Plan:
- DATA_W=32, LB addr 0x...3, mem_rdata=0x80FF_0011, zero-wait → resp_valid at cycle 2, resp_rdata=0xFFFF_FF80. Repeat as LBU → 0x0000_0080.
- SH addr 0x...2, wdata=0x0000_BEEF → mem_be=4'b1100, mem_wdata=0xBEEF_BEEF, mem_we=1, resp_rdata=0.
- LW with mem_ready delayed 3 cycles → busy high 4 cycles, request fields stable throughout, resp_rdata=mem_rdata.
- mem_ready held 0, MAX_WAIT=15 → resp_exc=10 after 15 wait cycles, mem_req low in RESP.
- MEM_ALIGN_EXC_EN defined, LW addr 0x...2 → exc=01 at cycle 1, mem_req never asserted. Undefined → access at addr 0x...0.
- reset asserted mid-ACCESS → next cycle mem_req=0, busy=0, no resp_valid. DATA_W=64 LD addr 0x8 → mem_be=8'hFF.
